// File: rtl/e_mdu_level.sv
// e_mdu_level: execute stage (E register + ALU) with a multi-cycle HI/LO multiply/divide unit
// and E-stage forwarding outputs. Define MDU_MADD_EN to add SPECIAL2 madd/maddu.
module e_mdu_level #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Flush,
    input  logic [31:0] IR_in,
    input  logic [31:0] PC_in,
    input  logic [31:0] RS_in,
    input  logic [31:0] RT_in,
    input  logic [31:0] EXT_in,
    input  logic        D_IsMD_in,
    output logic [31:0] IR_out,
    output logic [31:0] PC_out,
    output logic [31:0] RT_out,
    output logic [31:0] Result_out,
    output logic [4:0]  E_RFA3_out,
    output logic [31:0] E_RFWD_out,
    output logic        E_RFWr_out,
    output logic        E_Forward_Ready_out,
    output logic        Busy_out,
    output logic        Stall_req_out
);
    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [5:0] OP_RTYPE = 6'b000000, OP_ORI = 6'b001101, OP_LUI = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011, OP_SW  = 6'b101011, OP_JAL = 6'b000011;

    typedef enum logic [2:0] {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MADD, MD_MADDU} md_op_e;

    logic [31:0] ir_q, ir_d, pc_q, pc_d, rs_q, rs_d, rt_q, rt_d, ext_q, ext_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d, opa_q, opa_d, opb_q, opb_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    md_op_e md_op_q, md_op_d;

    logic [5:0] op, funct;
    logic [4:0] rt_f, rd_f, shamt;
    assign op    = ir_q[31:26];
    assign funct = ir_q[5:0];
    assign rt_f  = ir_q[20:16];
    assign rd_f  = ir_q[15:11];
    assign shamt = ir_q[10:6];

    logic is_r, i_addu, i_subu, i_and, i_or, i_slt, i_sll;
    logic i_mult, i_multu, i_div, i_divu, i_mfhi, i_mflo, i_mthi, i_mtlo;
    logic i_ori, i_lui, i_lw, i_sw, i_jal, i_madd, i_maddu;
    assign is_r    = (op == OP_RTYPE);
    assign i_addu  = is_r && (funct == 6'b100001);
    assign i_subu  = is_r && (funct == 6'b100011);
    assign i_and   = is_r && (funct == 6'b100100);
    assign i_or    = is_r && (funct == 6'b100101);
    assign i_slt   = is_r && (funct == 6'b101010);
    assign i_sll   = is_r && (funct == 6'b000000);
    assign i_mult  = is_r && (funct == 6'b011000);
    assign i_multu = is_r && (funct == 6'b011001);
    assign i_div   = is_r && (funct == 6'b011010);
    assign i_divu  = is_r && (funct == 6'b011011);
    assign i_mfhi  = is_r && (funct == 6'b010000);
    assign i_mthi  = is_r && (funct == 6'b010001);
    assign i_mflo  = is_r && (funct == 6'b010010);
    assign i_mtlo  = is_r && (funct == 6'b010011);
    assign i_ori   = (op == OP_ORI);
    assign i_lui   = (op == OP_LUI);
    assign i_lw    = (op == OP_LW);
    assign i_sw    = (op == OP_SW);
    assign i_jal   = (op == OP_JAL);
`ifdef MDU_MADD_EN
    assign i_madd  = (op == 6'b011100) && (funct == 6'b000000);
    assign i_maddu = (op == 6'b011100) && (funct == 6'b000001);
`else
    assign i_madd  = 1'b0;
    assign i_maddu = 1'b0;
`endif

    logic busy, start;
    assign busy  = (cnt_q != '0);
    assign start = (i_mult || i_multu || i_div || i_divu || i_madd || i_maddu) && !busy;

    // Products/quotients come from the operands latched at start, so E may move on meanwhile.
    logic [63:0] prod_s, prod_u;
    logic [31:0] quo_s, rem_s, quo_u, rem_u;
    logic        div_zero;
    assign prod_s   = {{32{opa_q[31]}}, opa_q} * {{32{opb_q[31]}}, opb_q};
    assign prod_u   = {32'b0, opa_q} * {32'b0, opb_q};
    assign div_zero = (opb_q == '0);
    assign quo_s    = div_zero ? '0 : 32'($signed(opa_q) / $signed(opb_q));
    assign rem_s    = div_zero ? '0 : 32'($signed(opa_q) % $signed(opb_q));
    assign quo_u    = div_zero ? '0 : opa_q / opb_q;
    assign rem_u    = div_zero ? '0 : opa_q % opb_q;

    always_comb begin
        ir_d  = Flush ? '0 : IR_in;
        pc_d  = Flush ? '0 : PC_in;
        rs_d  = Flush ? '0 : RS_in;
        rt_d  = Flush ? '0 : RT_in;
        ext_d = Flush ? '0 : EXT_in;
    end

    always_comb begin
        cnt_d   = cnt_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        md_op_d = md_op_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        if (start) begin
            opa_d = rs_q;
            opb_d = rt_q;
            cnt_d = (i_div || i_divu) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            if (i_mult)       md_op_d = MD_MULT;
            else if (i_multu) md_op_d = MD_MULTU;
            else if (i_div)   md_op_d = MD_DIV;
            else if (i_divu)  md_op_d = MD_DIVU;
            else if (i_madd)  md_op_d = MD_MADD;
            else              md_op_d = MD_MADDU;
        end else if (busy) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                case (md_op_q)
                    MD_MULT:  {hi_d, lo_d} = prod_s;
                    MD_MULTU: {hi_d, lo_d} = prod_u;
                    MD_DIV:   if (!div_zero) begin lo_d = quo_s; hi_d = rem_s; end
                    MD_DIVU:  if (!div_zero) begin lo_d = quo_u; hi_d = rem_u; end
                    MD_MADD:  {hi_d, lo_d} = {hi_q, lo_q} + prod_s;
                    MD_MADDU: {hi_d, lo_d} = {hi_q, lo_q} + prod_u;
                    default:  ;
                endcase
            end
        end else if (i_mthi) begin
            hi_d = rs_q;
        end else if (i_mtlo) begin
            lo_d = rs_q;
        end
    end

    logic [31:0] result;
    logic [4:0]  a3;
    always_comb begin
        result = '0;
        a3     = '0;
        if (i_addu)      begin result = rs_q + rt_q; a3 = rd_f; end
        else if (i_subu) begin result = rs_q - rt_q; a3 = rd_f; end
        else if (i_and)  begin result = rs_q & rt_q; a3 = rd_f; end
        else if (i_or)   begin result = rs_q | rt_q; a3 = rd_f; end
        else if (i_slt)  begin result = {31'b0, ($signed(rs_q) < $signed(rt_q))}; a3 = rd_f; end
        else if (i_sll)  begin result = rt_q << shamt; a3 = rd_f; end
        else if (i_mfhi) begin result = hi_q; a3 = rd_f; end
        else if (i_mflo) begin result = lo_q; a3 = rd_f; end
        else if (i_ori)  begin result = rs_q | ext_q; a3 = rt_f; end
        else if (i_lui)  begin result = ext_q; a3 = rt_f; end
        else if (i_lw)   begin result = rs_q + ext_q; a3 = rt_f; end
        else if (i_sw)   begin result = rs_q + ext_q; end
        else if (i_jal)  begin result = pc_q + 32'd8; a3 = 5'd31; end
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            ir_q    <= '0;
            pc_q    <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            ext_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            cnt_q   <= '0;
            md_op_q <= MD_MULT;
        end else begin
            ir_q    <= ir_d;
            pc_q    <= pc_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            ext_q   <= ext_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            cnt_q   <= cnt_d;
            md_op_q <= md_op_d;
        end
    end

    assign IR_out              = ir_q;
    assign PC_out              = pc_q;
    assign RT_out              = rt_q;
    assign Result_out          = result;
    assign E_RFA3_out          = a3;
    assign E_RFWD_out          = result;
    assign E_RFWr_out          = (a3 != '0);
    assign E_Forward_Ready_out = i_jal || i_lui || i_mfhi || i_mflo;
    assign Busy_out            = busy;
    assign Stall_req_out       = D_IsMD_in && (start || busy);
endmodule

// File: tb/tb_e_mdu_level.sv
// Scoreboard bench for e_mdu_level: the driver queues cycle-tagged expectations, a negedge
// monitor compares them. Follows MDU_MADD_EN for the madd case.
module tb_e_mdu_level;
    localparam int unsigned MC = 5;
    localparam int unsigned DC = 10;

    localparam logic [31:0] NOP   = 32'h0000_0000;
    localparam logic [31:0] MULT  = 32'h012A_0018;
    localparam logic [31:0] DIV   = 32'h012A_001A;
    localparam logic [31:0] DIVU  = 32'h012A_001B;
    localparam logic [31:0] MFHI  = 32'h0000_4010;
    localparam logic [31:0] MFLO  = 32'h0000_4012;
    localparam logic [31:0] MTHI  = 32'h0120_0011;
    localparam logic [31:0] MTLO  = 32'h0120_0013;
    localparam logic [31:0] JAL   = 32'h0C00_0C00;
    localparam logic [31:0] ADDU  = 32'h012A_4021;
    localparam logic [31:0] ADDU0 = 32'h012A_0021;
    localparam logic [31:0] SUBU  = 32'h012A_4023;
    localparam logic [31:0] ANDI  = 32'h012A_4024;
    localparam logic [31:0] ORR   = 32'h012A_4025;
    localparam logic [31:0] SLT   = 32'h012A_402A;
    localparam logic [31:0] SLL   = 32'h000A_4100;
    localparam logic [31:0] ORI   = 32'h3528_0000;
    localparam logic [31:0] LUI   = 32'h3C08_0000;
    localparam logic [31:0] LW    = 32'h8D28_0000;
    localparam logic [31:0] SW    = 32'hAD2A_0000;
    localparam logic [31:0] MADD  = 32'h712A_0000;

    localparam int S_IR = 0, S_RES = 1, S_A3 = 2, S_WD = 3, S_WR = 4, S_RDY = 5,
                   S_BUSY = 6, S_STALL = 7, S_PC = 8, S_RT = 9;

    logic        Clk = 1'b0, Rst, Flush, D_IsMD_in;
    logic [31:0] IR_in, PC_in, RS_in, RT_in, EXT_in;
    logic [31:0] IR_out, PC_out, RT_out, Result_out, E_RFWD_out;
    logic [4:0]  E_RFA3_out;
    logic        E_RFWr_out, E_Forward_Ready_out, Busy_out, Stall_req_out;

    e_mdu_level #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .Clk(Clk), .Rst(Rst), .Flush(Flush), .IR_in(IR_in), .PC_in(PC_in), .RS_in(RS_in),
        .RT_in(RT_in), .EXT_in(EXT_in), .D_IsMD_in(D_IsMD_in), .IR_out(IR_out), .PC_out(PC_out),
        .RT_out(RT_out), .Result_out(Result_out), .E_RFA3_out(E_RFA3_out), .E_RFWD_out(E_RFWD_out),
        .E_RFWr_out(E_RFWr_out), .E_Forward_Ready_out(E_Forward_Ready_out), .Busy_out(Busy_out),
        .Stall_req_out(Stall_req_out)
    );

    always #5 Clk = ~Clk;

    int unsigned cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned tag;
        int          sel;
        logic [31:0] val;
    } exp_t;
    exp_t sb[$];
    int total = 0, bad = 0;
    logic [31:0] act;

    function automatic string sel_name(input int sel);
        case (sel)
            S_IR: return "IR_out";       S_RES: return "Result_out";
            S_A3: return "E_RFA3";       S_WD: return "E_RFWD";
            S_WR: return "E_RFWr";       S_RDY: return "Forward_Ready";
            S_BUSY: return "Busy_out";   S_STALL: return "Stall_req";
            S_PC: return "PC_out";       default: return "RT_out";
        endcase
    endfunction

    function automatic logic [31:0] actual(input int sel);
        case (sel)
            S_IR: return IR_out;                       S_RES: return Result_out;
            S_A3: return {27'b0, E_RFA3_out};          S_WD: return E_RFWD_out;
            S_WR: return {31'b0, E_RFWr_out};          S_RDY: return {31'b0, E_Forward_Ready_out};
            S_BUSY: return {31'b0, Busy_out};          S_STALL: return {31'b0, Stall_req_out};
            S_PC: return PC_out;                       default: return RT_out;
        endcase
    endfunction

    function automatic logic is_md_start(input logic [31:0] ir);
        return (ir[31:26] == 6'b0) && (ir[5:2] == 4'b0110);
    endfunction

    always @(negedge Clk) begin
        for (int i = int'(sb.size()) - 1; i >= 0; i--) begin
            if (sb[i].tag == cyc) begin
                act = actual(sb[i].sel);
                total++;
                if (act !== sb[i].val) begin
                    bad++;
                    $display("FAIL %s cyc=%0d got=%h want=%h", sel_name(sb[i].sel), cyc, act, sb[i].val);
                end
                sb.delete(i);
            end
        end
        assert (!(Rst && Busy_out && is_md_start(IR_out)))
            else $error("FAIL md_start_while_busy cyc=%0d", cyc);
    end

    task automatic expect_at(input int unsigned tag, input int sel, input logic [31:0] v);
        exp_t e;
        e.tag = tag; e.sel = sel; e.val = v;
        sb.push_back(e);
    endtask

    task automatic issue(input logic [31:0] ir, input logic [31:0] pc, input logic [31:0] rs,
                         input logic [31:0] rt, input logic [31:0] ext, input logic fl);
        IR_in = ir; PC_in = pc; RS_in = rs; RT_in = rt; EXT_in = ext; Flush = fl;
        @(posedge Clk);
        #1;
    endtask

    task automatic nop();
        issue(NOP, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic alu(input logic [31:0] ir, input logic [31:0] pc, input logic [31:0] rs,
                       input logic [31:0] rt, input logic [31:0] ext, input logic [31:0] res,
                       input logic [4:0] a3, input logic wr, input logic rdy);
        issue(ir, pc, rs, rt, ext, 1'b0);
        expect_at(cyc, S_RES, res);
        expect_at(cyc, S_A3, {27'b0, a3});
        expect_at(cyc, S_WR, {31'b0, wr});
        expect_at(cyc, S_RDY, {31'b0, rdy});
        if (rdy) expect_at(cyc, S_WD, res);
    endtask

    task automatic read_hilo(input logic [31:0] hi, input logic [31:0] lo);
        issue(MFHI, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        expect_at(cyc, S_WD, hi);
        expect_at(cyc, S_RDY, 32'd1);
        expect_at(cyc, S_A3, 32'd8);
        expect_at(cyc, S_WR, 32'd1);
        issue(MFLO, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        expect_at(cyc, S_WD, lo);
    endtask

    int unsigned base;

    initial begin
        Rst = 1'b0; Flush = 1'b0; D_IsMD_in = 1'b1;
        IR_in = '0; PC_in = '0; RS_in = '0; RT_in = '0; EXT_in = '0;
        nop();
        expect_at(cyc, S_IR, 32'h0);
        expect_at(cyc, S_BUSY, 32'h0);
        expect_at(cyc, S_WR, 32'h0);
        expect_at(cyc, S_A3, 32'h0);
        expect_at(cyc, S_STALL, 32'h0);
        Rst = 1'b1;

        // reset in the middle of a mult
        issue(MTHI, 32'h0, 32'hAAAA_5555, 32'h0, 32'h0, 1'b0);
        issue(MULT, 32'h0, 32'hFFFF_FFFE, 32'd3, 32'h0, 1'b0);
        expect_at(cyc, S_STALL, 32'd1);
        nop();
        expect_at(cyc, S_BUSY, 32'd1);
        Rst = 1'b0;
        nop();
        expect_at(cyc, S_BUSY, 32'd0);
        expect_at(cyc, S_STALL, 32'd0);
        Rst = 1'b1;
        read_hilo(32'h0, 32'h0);

        // mult -2 * 3, busy window and stall window
        issue(MULT, 32'h0, 32'hFFFF_FFFE, 32'd3, 32'h0, 1'b0);
        base = cyc;
        for (int unsigned k = 0; k <= MC + 1; k++) begin
            expect_at(base + k, S_BUSY, {31'b0, (k >= 1 && k <= MC)});
            expect_at(base + k, S_STALL, {31'b0, (k <= MC)});
        end
        repeat (MC + 1) nop();
        read_hilo(32'hFFFF_FFFF, 32'hFFFF_FFFA);

        // div -7 / 2, then divu by zero leaves HI/LO alone
        issue(DIV, 32'h0, 32'hFFFF_FFF9, 32'd2, 32'h0, 1'b0);
        base = cyc;
        expect_at(base + 1, S_BUSY, 32'd1);
        expect_at(base + DC, S_BUSY, 32'd1);
        expect_at(base + DC + 1, S_BUSY, 32'd0);
        repeat (DC + 1) nop();
        read_hilo(32'hFFFF_FFFF, 32'hFFFF_FFFD);
        issue(DIVU, 32'h0, 32'd7, 32'd0, 32'h0, 1'b0);
        base = cyc;
        expect_at(base + DC, S_BUSY, 32'd1);
        expect_at(base + DC + 1, S_BUSY, 32'd0);
        repeat (DC + 1) nop();
        read_hilo(32'hFFFF_FFFF, 32'hFFFF_FFFD);

        // ALU, link and forwarding
        alu(JAL,   32'h3000, 32'h0, 32'h0, 32'h0, 32'h3008, 5'd31, 1'b1, 1'b1);
        expect_at(cyc, S_PC, 32'h3000);
        alu(ADDU,  32'h0, 32'd5, 32'd7, 32'h0, 32'd12, 5'd8, 1'b1, 1'b0);
        alu(ADDU0, 32'h0, 32'd5, 32'd7, 32'h0, 32'd12, 5'd0, 1'b0, 1'b0);
        alu(SUBU,  32'h0, 32'd5, 32'd7, 32'h0, 32'hFFFF_FFFE, 5'd8, 1'b1, 1'b0);
        alu(ANDI,  32'h0, 32'hF0F0, 32'hFF00, 32'h0, 32'hF000, 5'd8, 1'b1, 1'b0);
        alu(ORR,   32'h0, 32'hF0F0, 32'hFF00, 32'h0, 32'hFFF0, 5'd8, 1'b1, 1'b0);
        alu(SLT,   32'h0, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'd1, 5'd8, 1'b1, 1'b0);
        alu(SLT,   32'h0, 32'd1, 32'hFFFF_FFFF, 32'h0, 32'd0, 5'd8, 1'b1, 1'b0);
        alu(SLL,   32'h0, 32'h0, 32'd3, 32'h0, 32'h30, 5'd8, 1'b1, 1'b0);
        alu(ORI,   32'h0, 32'hF0, 32'h0, 32'hF, 32'hFF, 5'd8, 1'b1, 1'b0);
        alu(LUI,   32'h0, 32'h0, 32'h0, 32'hABCD_0000, 32'hABCD_0000, 5'd8, 1'b1, 1'b1);
        alu(LW,    32'h0, 32'h100, 32'h0, 32'd8, 32'h108, 5'd8, 1'b1, 1'b0);
        alu(SW,    32'h0, 32'h100, 32'hDEAD_BEEF, 32'd4, 32'h104, 5'd0, 1'b0, 1'b0);
        expect_at(cyc, S_RT, 32'hDEAD_BEEF);

        // mthi/mfhi, flush bubble, flush does not cancel the MDU
        issue(MTHI, 32'h0, 32'h1234_5678, 32'h0, 32'h0, 1'b0);
        issue(MFHI, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        expect_at(cyc, S_WD, 32'h1234_5678);
        expect_at(cyc, S_RDY, 32'd1);
        expect_at(cyc, S_A3, 32'd8);
        issue(ADDU, 32'h44, 32'd1, 32'd2, 32'd3, 1'b1);
        expect_at(cyc, S_IR, 32'h0);
        expect_at(cyc, S_WR, 32'h0);
        expect_at(cyc, S_PC, 32'h0);
        issue(MULT, 32'h0, 32'd6, 32'd7, 32'h0, 1'b0);
        base = cyc;
        expect_at(base + 1, S_BUSY, 32'd1);
        repeat (MC) issue(ADDU, 32'h0, 32'd1, 32'd2, 32'h0, 1'b1);
        read_hilo(32'h0, 32'd42);

        // madd accumulate, or no-op when the feature is compiled out
        issue(MTLO, 32'h0, 32'd10, 32'h0, 32'h0, 1'b0);
        issue(MTHI, 32'h0, 32'd0, 32'h0, 32'h0, 1'b0);
        issue(MADD, 32'h0, 32'd3, 32'd4, 32'h0, 1'b0);
        base = cyc;
        expect_at(base, S_WR, 32'd0);
`ifdef MDU_MADD_EN
        expect_at(base + 1, S_BUSY, 32'd1);
        expect_at(base + MC + 1, S_BUSY, 32'd0);
        repeat (MC + 1) nop();
        read_hilo(32'h0, 32'd22);
`else
        expect_at(base + 1, S_BUSY, 32'd0);
        repeat (MC + 1) nop();
        read_hilo(32'h0, 32'd10);
`endif

        repeat (3) nop();
        foreach (sb[i]) begin
            total++;
            bad++;
            $display("FAIL unchecked_%s tag=%0d got=none want=%h", sel_name(sb[i].sel), sb[i].tag, sb[i].val);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/e_mdu_level.md
Name: e_mdu_level

Overview:
- Execute-stage level of the 5-stage MIPS pipeline. Holds the E pipeline register and an ALU.
- Contains a multi-cycle multiply/divide unit (MDU) with HI/LO registers.
- Producer side of the forwarding interface consumed by the decode stage. Drives E_RFA3/E_RFWD/E_RFWr/E_Forward_Ready and the HI/LO structural stall request.
- Sits between the decode level and the memory level.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (and madd/maddu when enabled)
- DIV_CYCLES, 10, busy cycles for div/divu

Ports:
- Clk  input  1  pipeline clock
- Rst  input  1  synchronous, active-low reset
- Flush  input  1  load a bubble (all-zero IR/PC/RS/RT/EXT) into E register; driven while D stalls
- IR_in  input  32  instruction from D
- PC_in  input  32  PC from D
- RS_in  input  32  forwarded rs value from D
- RT_in  input  32  forwarded rt value from D
- EXT_in  input  32  extended immediate from D
- D_IsMD_in  input  1  D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo (/madd/maddu)
- IR_out  output  32  E-register IR, to M
- PC_out  output  32  E-register PC, to M
- RT_out  output  32  E-register RT (store data), to M
- Result_out  output  32  ALU/MDU/link result, to M
- E_RFA3_out  output  5  destination register of the instruction in E
- E_RFWD_out  output  32  forward data from E
- E_RFWr_out  output  1  instruction in E writes the GRF
- E_Forward_Ready_out  output  1  E_RFWD_out is valid this cycle
- Busy_out  output  1  MDU operation in progress
- Stall_req_out  output  1  D must stall for an HI/LO hazard

Behaviour:
- Reset (Rst==0 at posedge):
  - E register cleared to zero, so IR=nop.
  - HI=LO=0, counter=0, Busy_out=0.
  - All outputs derived from a nop: RFWr=0, RFA3=0, Stall_req=0.
- E register:
  - Loads every cycle with no enable.
  - Flush=1 loads zeros; Flush has priority below reset.
- Decode (standard MIPS encodings):
  - R-type addu, subu, and, or, slt, sll, jr, plus the MDU functs.
  - I-type ori, lui, lw, sw, beq; J-type jal.
- Destination register (RFA3):
  - rd for addu/subu/and/or/slt/sll/mfhi/mflo.
  - rt for ori/lui/lw.
  - 31 for jal.
  - Otherwise 0.
  - RFWr=1 iff RFA3!=0 and the instruction writes.
- Results:
  - ALU: addu/subu 32-bit wrap; slt signed compare; ori zero-ext via EXT_in; lui = EXT_in; sll uses shamt.
  - lw/sw address = RS+EXT.
  - jal result = PC+8.
- Forwarding from E:
  - E_Forward_Ready=1 only for jal, lui, mfhi and mflo; 0 for all other instructions.
  - E_RFWD = PC+8 for jal, EXT for lui, current HI/LO for mfhi/mflo.
- MDU start:
  - Start = (IR is mult/multu/div/divu) && !Busy.
  - On Start, operands are latched and the counter loads MULT_CYCLES or DIV_CYCLES.
  - Busy_out=1 from the next cycle.
  - The counter decrements each cycle. When the counter reaches 1, HI/LO are written at that edge and Busy_out falls.
  - Total latency is N cycles after the start edge.
- MDU results:
  - mult: signed 64-bit product, HI=upper, LO=lower.
  - multu: unsigned 64-bit product, HI=upper, LO=lower.
  - div/divu: LO=quotient, HI=remainder; signed division truncates toward zero and the remainder takes the dividend's sign.
  - Divisor 0: HI/LO unchanged; busy duration still DIV_CYCLES.
- mthi/mtlo: write HI/LO at the next edge with no busy period.
- Stall request:
  - Stall_req_out = D_IsMD_in && (Start || Busy_out).
  - mfhi/mflo never read stale HI/LO.
- Error case: an MDU start while Busy is ignored. The hazard unit guarantees this cannot occur; the bench asserts it.
- Flush does not cancel a running MDU operation.
- Reset mid-operation aborts the operation: counter=0, HI=LO=0.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined:
  - SPECIAL2 op 011100, funct 000000 = madd, funct 000001 = maddu.
  - {HI,LO} += signed (madd) or unsigned (maddu) RS*RT, modulo 2^64.
  - Latency MULT_CYCLES; counts as an MDU start and for D_IsMD_in.
- Undefined: these encodings decode as nop (no write, no busy).

Test Plan:
1. Reset mid-mult: reset asserted during a mult -> next cycle HI=LO=0, Busy_out=0.
2. mult with RS=0xFFFFFFFE (-2), RT=3 -> Busy_out high for 5 cycles. Then HI=0xFFFFFFFF, LO=0xFFFFFFFA. With D_IsMD_in=1, Stall_req_out high from the Start cycle until Busy_out falls.
3. div RS=-7, RT=2 -> after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 7/0 -> HI/LO unchanged, busy 10 cycles.
4. jal at PC=0x3000 in E -> E_RFA3=31, E_RFWD=0x3008, Forward_Ready=1, RFWr=1. addu $t0 -> Forward_Ready=0, Result_out=sum.
5. mthi with RS=0x12345678 then mfhi $8 -> E_RFWD=0x12345678, Ready=1, RFA3=8. Flush cycle -> IR_out=0, RFWr=0.
6. (MDU_MADD_EN) HI/LO=0/10, madd RS=3, RT=4 -> after 5 cycles LO=22, HI=0. Without the macro -> no change, Busy_out stays 0.
